// File: rtl/screen_clear_pkg.sv
// Shared display-path types for the frame-buffer clear engine.
// Holds the fill FSM encoding and the default display RAM geometry.
package screen_clear_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    localparam int DISP_ADDR_WIDTH = 10;
    localparam int DISP_DATA_WIDTH = 16;

endpackage

// File: rtl/screen_clear.sv
// Frame-buffer clear engine on RAM port B.
// Fills every word with a latched value; otherwise lends port B to the VGA scan.
module screen_clear
    import screen_clear_pkg::*;
#(
    parameter int ADDR_WIDTH = DISP_ADDR_WIDTH,
    parameter int DATA_WIDTH = DISP_DATA_WIDTH
) (
    input  logic                  CLK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] fill_value,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_data_b,
    output logic                  ram_wren_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b,
    output logic [DATA_WIDTH-1:0] pixel_word,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0] LAST_CNT = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    fill_state_t           r_state;
    fill_state_t           w_next;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [DATA_WIDTH-1:0] r_fill;
    logic                  r_blank;
    logic                  w_accept;
    logic                  w_last;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_last   = (r_cnt == LAST_CNT);

    // Reset launches a clear with value 0; blanking tracks last cycle's busy.
    always_ff @(posedge CLK_50) begin
        if (reset) begin
            r_state <= ST_FILL;
            r_cnt   <= '0;
            r_fill  <= '0;
            r_blank <= 1'b1;
        end else begin
            r_state <= w_next;
            r_blank <= busy;
            if (w_accept) begin
                r_cnt  <= '0;
                r_fill <= fill_value;
            end else if (r_state == ST_FILL) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    // Next state and port-B / status decode from the registered state.
    always_comb begin
        w_next     = r_state;
        ram_addr_b = vga_addr;
        ram_wren_b = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_FILL;
            end
            ST_FILL: begin
                ram_addr_b = r_cnt[ADDR_WIDTH-1:0];
                ram_wren_b = 1'b1;
                busy       = 1'b1;
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign ram_data_b = r_fill;
    assign pixel_word = r_blank ? '0 : ram_q_b;

endmodule

// File: tb/tb_screen_clear.sv
// Scoreboard bench for screen_clear with a behavioural port-B RAM.
// Expected writes are queued at stimulus time and popped by a monitor.
module tb_screen_clear;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int WORDS = 1 << AW;

    logic          CLK_50 = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] fill_value;
    logic [AW-1:0] vga_addr;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_data_b;
    logic          ram_wren_b;
    logic [DW-1:0] ram_q_b;
    logic [DW-1:0] pixel_word;
    logic          busy;
    logic          done;

    always #10 CLK_50 = ~CLK_50;

    screen_clear #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK_50     (CLK_50),
        .reset      (reset),
        .start      (start),
        .fill_value (fill_value),
        .vga_addr   (vga_addr),
        .ram_addr_b (ram_addr_b),
        .ram_data_b (ram_data_b),
        .ram_wren_b (ram_wren_b),
        .ram_q_b    (ram_q_b),
        .pixel_word (pixel_word),
        .busy       (busy),
        .done       (done)
    );

    logic [DW-1:0] mem [WORDS];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    // Port-B RAM: one-cycle read latency, plus a bench backdoor write.
    always @(posedge CLK_50) begin
        if (ram_wren_b) mem[ram_addr_b] <= ram_data_b;
        else if (bd_we) mem[bd_addr] <= bd_data;
        ram_q_b <= mem[ram_addr_b];
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           wq[$];
    bit            done_due = 0;
    bit            started = 0;
    bit            rst_q = 0;
    logic [DW-1:0] ref_mem [WORDS];
    int            tests = 0;
    int            fails = 0;

    // Reset level seen by the DUT at the most recent edge.
    always @(posedge CLK_50) rst_q <= reset;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_idle();
        return !reset && !rst_q && wq.size() == 0 && !done_due;
    endfunction

    task automatic push_fill(logic [DW-1:0] v);
        wq.delete();
        for (int i = 0; i < WORDS; i++) begin
            wq.push_back('{a: AW'(i), d: v});
            ref_mem[i] = v;
        end
        done_due = 1;
    endtask

    bit            prev_mb = 0;
    bit            prev_idle = 0;
    bit            prev_valid = 0;
    logic [DW-1:0] prev_ref;

    // Monitor: compares DUT outputs against the model mid-cycle.
    always @(negedge CLK_50) begin
        bit  mb;
        bit  idle;
        wr_t e;
        if (started) begin
            mb   = rst_q || wq.size() > 0;
            idle = !rst_q && !reset && wq.size() == 0 && !done_due;
            if (prev_valid)
                chk("pixel", 32'(pixel_word),
                    (rst_q || prev_mb) ? 32'd0 : 32'(ram_q_b));
            if (prev_valid && prev_idle && !rst_q)
                chk("readback", 32'(pixel_word), 32'(prev_ref));
            if (rst_q && reset) begin
                chk("rst_busy", 32'(busy), 32'd1);
                chk("rst_wren", 32'(ram_wren_b), 32'd1);
                chk("rst_addr", 32'(ram_addr_b), 32'd0);
                chk("rst_data", 32'(ram_data_b), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
            end else if (!reset) begin
                chk("busy", 32'(busy), 32'(mb));
                chk("done", 32'(done), 32'(done_due && wq.size() == 0));
                chk("wren", 32'(ram_wren_b), 32'(wq.size() > 0));
                if (wq.size() == 0 && done_due) done_due = 0;
                if (wq.size() > 0) begin
                    e = wq.pop_front();
                    chk("wr_addr", 32'(ram_addr_b), 32'(e.a));
                    chk("wr_data", 32'(ram_data_b), 32'(e.d));
                end
                if (idle) chk("idle_addr", 32'(ram_addr_b), 32'(vga_addr));
            end
            prev_mb    = mb;
            prev_idle  = idle;
            prev_ref   = ref_mem[vga_addr];
            prev_valid = 1;
        end
    end

    task automatic tick();
        @(posedge CLK_50);
        #1;
    endtask

    task automatic do_start(logic [DW-1:0] v);
        bit acc;
        acc = model_idle();
        start = 1'b1;
        fill_value = v;
        @(posedge CLK_50);
        if (acc) push_fill(v);
        #1;
        start = 1'b0;
        fill_value = DW'($urandom);
    endtask

    task automatic do_reset(int n, bit with_start);
        reset = 1'b1;
        start = with_start;
        fill_value = 16'hBEEF;
        tick();
        start = 1'b0;
        repeat (n - 1) tick();
        reset = 1'b0;
        push_fill('0);
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while (!model_idle() && n < budget) begin
            tick();
            n++;
        end
        if (!model_idle()) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: fill not finished after %0d cycles", budget);
        end
    endtask

    task automatic readback_rand(int n);
        for (int k = 0; k < n; k++) begin
            vga_addr = AW'($urandom);
            tick();
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fill_value = '0;
        vga_addr = '0;
        bd_we = 1'b0;
        bd_addr = '0;
        bd_data = '0;
        @(posedge CLK_50);
        #1;
        started = 1;
        repeat (2) tick();
        reset = 1'b0;
        push_fill('0);
        wait_idle(1100);
        readback_rand(16);

        do_start(16'hA5A5);
        repeat (99) tick();
        do_start(16'h1234);
        wait_idle(1100);
        for (int a = 0; a < WORDS; a++) begin
            vga_addr = AW'(a);
            tick();
        end
        tick();

        vga_addr = '0;
        for (int a = 5; a <= 7; a++) begin
            bd_we = 1'b1;
            bd_addr = AW'(a);
            bd_data = DW'(a);
            ref_mem[a] = DW'(a);
            tick();
        end
        bd_we = 1'b0;
        tick();
        for (int a = 5; a <= 7; a++) begin
            vga_addr = AW'(a);
            tick();
        end
        tick();

        do_start(16'hFFFF);
        repeat (499) tick();
        do_reset(2, 1'b0);
        wait_idle(1100);
        readback_rand(32);

        for (int it = 0; it < 3; it++) begin
            repeat ($urandom_range(1, 20)) begin
                vga_addr = AW'($urandom);
                tick();
            end
            do_start(DW'($urandom));
            repeat ($urandom_range(0, 900)) tick();
            do_start(DW'($urandom));
            wait_idle(1100);
            readback_rand(20);
        end

        do_reset(1, 1'b1);
        wait_idle(1100);
        readback_rand(16);

        chk("drain_q", 32'(wq.size()), 32'd0);
        chk("drain_done", 32'(done_due), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
